// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle parametrised CPU datapath (decode, 16x register file, Z/N/V flags,
// hardware stack, ready-handshaked data memory). Define DATAPATH_MC_STACK_CHECK_EN for stack fault trapping.
module datapath_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] SP_RESET = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       programData,
  input  logic [DATA_W-1:0] readData,
  input  logic              memReady,
  output logic [ADDR_W-1:0] programAddress,
  output logic [ADDR_W-1:0] dataAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              WE,
  output logic              RE,
  output logic              halted,
  output logic              stackFault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_LDI  = 4'h5, OP_ADDI = 4'h6, OP_LD  = 4'h7,
    OP_ST   = 4'h8, OP_PUSH = 4'h9, OP_POP  = 4'hA, OP_CMP = 4'hB,
    OP_JMP  = 4'hC, OP_JZ   = 4'hD, OP_JN   = 4'hE, OP_HALT = 4'hF
  } op_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] opd_q, opd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              z_q, z_d, n_q, n_d, v_q, v_d;
  logic              we_q, we_d, re_q, re_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];

  op_e               op;
  logic [3:0]        rd;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_a, alu_b, alu_b_eff, alu_sum, logic_res;
  logic              alu_sub, alu_v;
  logic              writes_rd, push_fault, pop_fault;

  assign op  = op_e'(ir_q[15:12]);
  assign rd  = ir_q[11:8];
  assign imm = DATA_W'($signed(ir_q[7:0]));

`ifdef DATAPATH_MC_STACK_CHECK_EN
  assign push_fault = (sp_q == '0);
  assign pop_fault  = (sp_q == SP_RESET);
`else
  assign push_fault = 1'b0;
  assign pop_fault  = 1'b0;
`endif

  // One shared adder: subtraction is a + ~b + 1, so overflow uses the inverted b operand.
  always_comb begin
    alu_a   = opa_q;
    alu_b   = opb_q;
    alu_sub = 1'b0;
    case (op)
      OP_SUB, OP_CMP: alu_sub = 1'b1;
      OP_ADDI: begin
        alu_a = opd_q;
        alu_b = imm;
      end
      default: ;
    endcase
  end

  assign alu_b_eff = alu_sub ? ~alu_b : alu_b;
  assign alu_sum   = alu_a + alu_b_eff + DATA_W'(alu_sub);
  assign alu_v     = (alu_a[DATA_W-1] == alu_b_eff[DATA_W-1]) &&
                     (alu_sum[DATA_W-1] != alu_a[DATA_W-1]);
  assign logic_res = (op == OP_AND) ? (opa_q & opb_q) : (opa_q | opb_q);

  always_comb begin
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_ADDI, OP_LD, OP_POP: writes_rd = 1'b1;
      default:                                                       writes_rd = 1'b0;
    endcase
  end

  // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    prog_addr_d = prog_addr_q;
    sp_d        = sp_q;
    data_addr_d = data_addr_q;
    ir_d        = ir_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opd_d       = opd_q;
    res_d       = res_q;
    mdr_d       = mdr_q;
    wdata_d     = wdata_q;
    z_d         = z_q;
    n_d         = n_q;
    v_d         = v_q;
    we_d        = we_q;
    re_d        = re_q;
    fault_d     = fault_q;
    rf_d        = rf_q;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        // Operands are read straight off the instruction bus while IR is captured.
        ir_d    = programData;
        opa_d   = rf_q[programData[7:4]];
        opb_d   = rf_q[programData[3:0]];
        opd_d   = rf_q[programData[11:8]];
        state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_WB;
        case (op)
          OP_ADD, OP_SUB, OP_ADDI, OP_CMP: begin
            res_d = alu_sum;
            z_d   = (alu_sum == '0);
            n_d   = alu_sum[DATA_W-1];
            v_d   = alu_v;
          end
          OP_AND, OP_OR: begin
            res_d = logic_res;
            z_d   = (logic_res == '0);
            n_d   = logic_res[DATA_W-1];
            v_d   = 1'b0;
          end
          OP_LDI: res_d = imm;
          OP_LD: begin
            data_addr_d = opa_q[ADDR_W-1:0];
            re_d        = 1'b1;
            state_d     = S_MEM;
          end
          OP_ST: begin
            data_addr_d = opa_q[ADDR_W-1:0];
            wdata_d     = opd_q;
            we_d        = 1'b1;
            state_d     = S_MEM;
          end
          OP_PUSH: begin
            if (push_fault) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              data_addr_d = sp_q;
              wdata_d     = opd_q;
              we_d        = 1'b1;
              state_d     = S_MEM;
            end
          end
          OP_POP: begin
            if (pop_fault) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              data_addr_d = sp_q + ADDR_W'(1);
              re_d        = 1'b1;
              state_d     = S_MEM;
            end
          end
          OP_JMP: pc_d = opa_q[ADDR_W-1:0];
          OP_JZ:  if (z_q) pc_d = opa_q[ADDR_W-1:0];
          OP_JN:  if (n_q) pc_d = opa_q[ADDR_W-1:0];
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        if (memReady) begin
          we_d    = 1'b0;
          re_d    = 1'b0;
          mdr_d   = readData;
          state_d = S_WB;
        end
      end

      S_WB: begin
        if (writes_rd) rf_d[rd] = (op == OP_LD || op == OP_POP) ? mdr_q : res_q;
        if (op == OP_PUSH)     sp_d = sp_q - ADDR_W'(1);
        else if (op == OP_POP) sp_d = sp_q + ADDR_W'(1);
        prog_addr_d = pc_q;
        state_d     = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      prog_addr_q <= '0;
      sp_q        <= SP_RESET;
      data_addr_q <= '0;
      ir_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      opd_q       <= '0;
      res_q       <= '0;
      mdr_q       <= '0;
      wdata_q     <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      fault_q     <= 1'b0;
      // NOTE: the register file is built from flops and cleared on reset; it is not a RAM macro.
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      prog_addr_q <= prog_addr_d;
      sp_q        <= sp_d;
      data_addr_q <= data_addr_d;
      ir_q        <= ir_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opd_q       <= opd_d;
      res_q       <= res_d;
      mdr_q       <= mdr_d;
      wdata_q     <= wdata_d;
      z_q         <= z_d;
      n_q         <= n_d;
      v_q         <= v_d;
      we_q        <= we_d;
      re_q        <= re_d;
      fault_q     <= fault_d;
      rf_q        <= rf_d;
    end
  end

  assign programAddress = prog_addr_q;
  assign dataAddress    = data_addr_q;
  assign writeData      = wdata_q;
  assign WE             = we_q;
  assign RE             = re_q;
  assign halted         = (state_q == S_HALT);
  assign stackFault     = fault_q;

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: table-driven ALU/flag vectors plus hand-written sequences for timing,
// wait-states, stack, branches and asynchronous reset in the middle of a memory access.
`timescale 1ns/1ps
module tb_datapath_mc;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       programData;
  logic [DATA_W-1:0] readData;
  logic              memReady;
  logic [ADDR_W-1:0] programAddress, dataAddress;
  logic [DATA_W-1:0] writeData;
  logic              WE, RE, halted, stackFault;

  datapath_mc dut (
    .clk(clk), .reset(reset), .programData(programData), .readData(readData),
    .memReady(memReady), .programAddress(programAddress), .dataAddress(dataAddress),
    .writeData(writeData), .WE(WE), .RE(RE), .halted(halted), .stackFault(stackFault)
  );

  always #5 clk = ~clk;

  logic [15:0]       rom  [1024];
  logic [DATA_W-1:0] dmem [1024];
  int                wait_n, wait_cnt, we_cycles, re_cycles;
  logic              we_prev;
  logic [ADDR_W-1:0] we_addr_log [$];
  int                errors = 0;
  int                checks = 0;

  // ROM and data-memory responder, driven on the falling edge.
  always @(negedge clk) begin
    programData = rom[programAddress];
    if (WE || RE) begin
      if (WE) we_cycles++;
      if (RE) re_cycles++;
      if (WE && !we_prev) we_addr_log.push_back(dataAddress);
      if (wait_cnt >= wait_n) begin
        memReady = 1'b1;
        wait_cnt = 0;
        if (WE) dmem[dataAddress] = writeData;
        if (RE) readData = dmem[dataAddress];
      end else begin
        memReady = 1'b0;
        wait_cnt++;
      end
    end else begin
      memReady = 1'b0;
      wait_cnt = 0;
    end
    we_prev = WE;
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  znv;
  } vec_t;
  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rx, input logic [3:0] ry);
    return {op, rd, rx, ry};
  endfunction

  function automatic logic [15:0] insi(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = 16'hF000;
      dmem[i] = '0;
    end
    wait_n = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    we_cycles = 0;
    re_cycles = 0;
    we_addr_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset       = 1'b1;
    programData = '0;
    readData    = '0;
    memReady    = 1'b0;
    wait_n      = 0;
    wait_cnt    = 0;
    we_prev     = 1'b0;
    we_cycles   = 0;
    re_cycles   = 0;

    vecs[0]  = '{4'h1, 16'h0005, 16'hFFFD, 16'h0002, 3'b000};
    vecs[1]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 3'b011};
    vecs[2]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 3'b100};
    vecs[3]  = '{4'h1, 16'h8000, 16'h8000, 16'h0000, 3'b101};
    vecs[4]  = '{4'h2, 16'h0005, 16'h0005, 16'h0000, 3'b100};
    vecs[5]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 3'b001};
    vecs[6]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 3'b010};
    vecs[7]  = '{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
    vecs[8]  = '{4'h4, 16'h8000, 16'h0001, 16'h8001, 3'b010};
    vecs[9]  = '{4'h3, 16'h00FF, 16'hFF00, 16'h0000, 3'b100};
    vecs[10] = '{4'hB, 16'h0002, 16'h0005, 16'h0000, 3'b010};
    vecs[11] = '{4'hB, 16'h8000, 16'h0001, 16'h0000, 3'b001};

    // Reset state while reset is held.
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_prog_addr", programAddress, 0);
    check("rst_data_addr", dataAddress, 0);
    check("rst_write_data", writeData, 0);
    check("rst_we_re", {WE, RE}, 0);
    check("rst_halted", halted, 0);
    check("rst_stack_fault", stackFault, 0);
    check("rst_sp", dut.sp_q, 10'h3FE);
    check("rst_flags", {dut.z_q, dut.n_q, dut.v_q}, 0);

    // Table-driven ALU and flag vectors: operands loaded from memory, result stored back.
    for (int i = 0; i < NVEC; i++) begin
      clear_mem();
      dmem[10'h010] = vecs[i].a;
      dmem[10'h011] = vecs[i].b;
      dmem[10'h020] = 16'hDEAD;
      rom[0] = insi(4'h5, 4'd8, 8'h10);
      rom[1] = ins(4'h7, 4'd1, 4'd8, 4'd0);
      rom[2] = insi(4'h5, 4'd8, 8'h11);
      rom[3] = ins(4'h7, 4'd2, 4'd8, 4'd0);
      rom[4] = ins(vecs[i].op, 4'd3, 4'd1, 4'd2);
      rom[5] = insi(4'h5, 4'd8, 8'h20);
      rom[6] = ins(4'h8, 4'd3, 4'd8, 4'd0);
      rom[7] = ins(4'hF, 4'd0, 4'd0, 4'd0);
      do_reset();
      wait_halt($sformatf("vec%0d", i), 300);
      check($sformatf("vec%0d_result", i), dmem[10'h020], vecs[i].res);
      check($sformatf("vec%0d_flags", i), {dut.z_q, dut.n_q, dut.v_q}, vecs[i].znv);
    end

    // LDI/LDI/ADD: fourth fetch appears after exactly 12 cycles.
    clear_mem();
    rom[0] = insi(4'h5, 4'd1, 8'h05);
    rom[1] = insi(4'h5, 4'd2, 8'hFD);
    rom[2] = ins(4'h1, 4'd3, 4'd1, 4'd2);
    rom[3] = insi(4'h5, 4'd4, 8'h30);
    rom[4] = ins(4'h8, 4'd3, 4'd4, 4'd0);
    do_reset();
    cyc = 0;
    while (programAddress != 10'd3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("seq_add_cycles", cyc, 12);
    wait_halt("seq_add", 100);
    check("seq_add_r3", dmem[10'h030], 16'h0002);
    check("seq_add_flags", {dut.z_q, dut.n_q, dut.v_q}, 3'b000);

    // ADDI climbs to 0x7FFE, then +2 overflows; AND afterwards clears V.
    clear_mem();
    rom[0] = insi(4'h5, 4'd1, 8'h7F);
    for (int k = 1; k <= 257; k++) rom[k] = insi(4'h6, 4'd1, 8'h7F);
    rom[258] = insi(4'h6, 4'd1, 8'h02);
    rom[259] = insi(4'h5, 4'd4, 8'h31);
    rom[260] = ins(4'h8, 4'd1, 4'd4, 4'd0);
    rom[261] = ins(4'h3, 4'd5, 4'd1, 4'd1);
    do_reset();
    cyc = 0;
    while (!WE && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ovf_store_seen", WE, 1);
    check("ovf_store_data", writeData, 16'h8000);
    check("ovf_flags", {dut.z_q, dut.n_q, dut.v_q}, 3'b011);
    wait_halt("ovf", 100);
    check("ovf_mem", dmem[10'h031], 16'h8000);
    check("and_clears_v", {dut.z_q, dut.n_q, dut.v_q}, 3'b010);

    // ST with three wait cycles, then LD of the same word.
    clear_mem();
    wait_n = 3;
    rom[0] = insi(4'h5, 4'd4, 8'h55);
    rom[1] = insi(4'h5, 4'd5, 8'hA2);
    rom[2] = ins(4'h8, 4'd5, 4'd4, 4'd0);
    rom[3] = insi(4'h5, 4'd7, 8'h56);
    rom[4] = ins(4'h7, 4'd6, 4'd4, 4'd0);
    rom[5] = ins(4'h8, 4'd6, 4'd7, 4'd0);
    do_reset();
    cyc = 0;
    while (programAddress != 10'd3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("st_wait_cycles", cyc, 16);
    check("st_we_width", we_cycles, 4);
    check("st_addr", (we_addr_log.size() > 0) ? we_addr_log[0] : 10'h000, 10'h055);
    wait_halt("st_ld", 200);
    check("st_mem", dmem[10'h055], 16'hFFA2);
    check("ld_roundtrip", dmem[10'h056], 16'hFFA2);

    // PUSH r1, PUSH r2, POP r3, POP r4 with one wait cycle per access.
    clear_mem();
    wait_n = 1;
    rom[0]  = insi(4'h5, 4'd1, 8'h11);
    rom[1]  = insi(4'h5, 4'd2, 8'h22);
    rom[2]  = ins(4'h9, 4'd1, 4'd0, 4'd0);
    rom[3]  = ins(4'h9, 4'd2, 4'd0, 4'd0);
    rom[4]  = ins(4'hA, 4'd3, 4'd0, 4'd0);
    rom[5]  = ins(4'hA, 4'd4, 4'd0, 4'd0);
    rom[6]  = insi(4'h5, 4'd8, 8'h40);
    rom[7]  = ins(4'h8, 4'd3, 4'd8, 4'd0);
    rom[8]  = insi(4'h5, 4'd8, 8'h41);
    rom[9]  = ins(4'h8, 4'd4, 4'd8, 4'd0);
    do_reset();
    wait_halt("stack", 300);
    check("stack_writes", we_addr_log.size(), 4);
    check("push1_addr", (we_addr_log.size() > 0) ? we_addr_log[0] : 10'h000, 10'h3FE);
    check("push2_addr", (we_addr_log.size() > 1) ? we_addr_log[1] : 10'h000, 10'h3FD);
    check("pop_r3", dmem[10'h040], 16'h0022);
    check("pop_r4", dmem[10'h041], 16'h0011);
    check("stack_sp", dut.sp_q, 10'h3FE);

    // POP from an empty stack.
    clear_mem();
    dmem[10'h3FF] = 16'h1234;
    rom[0] = ins(4'hA, 4'd1, 4'd0, 4'd0);
    rom[1] = insi(4'h5, 4'd8, 8'h42);
    rom[2] = ins(4'h8, 4'd1, 4'd8, 4'd0);
    do_reset();
    wait_halt("pop_empty", 100);
`ifdef DATAPATH_MC_STACK_CHECK_EN
    check("pop_empty_fault", stackFault, 1);
    check("pop_empty_no_re", re_cycles, 0);
    check("pop_empty_no_we", we_cycles, 0);
    check("pop_empty_sp", dut.sp_q, 10'h3FE);
`else
    check("pop_empty_fault", stackFault, 0);
    check("pop_empty_re_seen", 32'(re_cycles != 0), 1);
    check("pop_empty_sp", dut.sp_q, 10'h3FF);
    check("pop_empty_value", dmem[10'h042], 16'h1234);
`endif

    // CMP r1,r1; JN not taken; JZ taken; then reset during a stalled store.
    clear_mem();
    rom[0]     = insi(4'h5, 4'd6, 8'h20);
    rom[1]     = insi(4'h5, 4'd7, 8'h30);
    rom[2]     = ins(4'hB, 4'd0, 4'd1, 4'd1);
    rom[3]     = ins(4'hE, 4'd0, 4'd7, 4'd0);
    rom[4]     = ins(4'hD, 4'd0, 4'd6, 4'd0);
    rom[10'h20] = insi(4'h5, 4'd8, 8'h43);
    rom[10'h21] = ins(4'h8, 4'd6, 4'd8, 4'd0);
    rom[10'h22] = ins(4'h8, 4'd7, 4'd8, 4'd0);
    do_reset();
    cyc = 0;
    while (!(we_addr_log.size() == 1 && !WE) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("jz_first_store", we_addr_log.size(), 1);
    check("jz_target_mem", dmem[10'h043], 16'h0020);
    wait_n = 50;
    cyc = 0;
    while (!WE && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stall_we", WE, 1);
    check("stall_addr", dataAddress, 10'h043);
    check("cmp_flags", {dut.z_q, dut.n_q, dut.v_q}, 3'b100);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midmem_we", WE, 0);
    check("midmem_re", RE, 0);
    check("midmem_prog_addr", programAddress, 0);
    check("midmem_data_addr", dataAddress, 0);
    check("midmem_write_data", writeData, 0);
    check("midmem_halted", halted, 0);
    check("midmem_sp", dut.sp_q, 10'h3FE);
    @(negedge clk);
    check("midmem_abandoned", dmem[10'h043], 16'h0020);
    wait_n = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
